clkdiv_multi: RTL

Multi-channel programmable clock divider, the parametrised successor to the fixed single-output `clkdiv`. It produces `CH` independent divided clock-level outputs, with a runtime-programmable divisor and an enable per channel. Each output has a matching one-cycle `tick` strobe for use as a clock enable. Divisor changes take effect only at a period boundary, so every output period is whole and never truncated. The block sits beside the system clock source and feeds blink, scan and baud-rate logic in the lab designs.

---
 rtl/clkdiv_multi_pkg.sv | 16 +
 rtl/clkdiv_multi_if.sv | 14 +
 rtl/clkdiv_multi_chan.sv | 69 ++++++
 rtl/clkdiv_multi.sv | 42 ++++
 4 files changed

// File: rtl/clkdiv_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Helpers work on 32-bit values so callers of any counter width can use them.
package clkdiv_pkg;

   localparam int unsigned DIV_MIN = 2;

   // Divisors below DIV_MIN cannot form a low and a high phase, so they are raised.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

   function automatic logic [31:0] half_up(input logic [31:0] p);
      return (p + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Divisor write bus shared by all channels of clkdiv_multi.
interface clkdiv_multi_if #(
   parameter int CH    = 2,
   parameter int CNT_W = 16
);
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

   logic              div_wr_en;
   logic [CH_W-1:0]   div_wr_ch;
   logic [CNT_W-1:0]  div_wr_data;

   modport master (output div_wr_en, output div_wr_ch, output div_wr_data);
   modport slave  (input  div_wr_en, input  div_wr_ch, input  div_wr_data);
endinterface

// File: rtl/clkdiv_multi_chan.sv
// One divider channel: phase counter, active/pending divisor and registered outputs.
// A new divisor is adopted only at a period wrap, or at once while the channel is stopped.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_wrEn,
   input  logic [CNT_W-1:0] i_wrData,
   output logic             o_clkOut,
   output logic             o_tick
);

   localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(clamp_div(32'(DIV_DEFAULT)));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pend;
   logic             r_pendV;

   logic             w_wrap;
   logic [CNT_W-1:0] w_half;
   logic [CNT_W-1:0] w_pendNext;
   logic             w_pendVNext;
   logic [CNT_W-1:0] w_pendClamped;

   // A write in the current cycle bypasses the pending register so it can land on this wrap.
   assign w_pendNext    = i_wrEn ? i_wrData : r_pend;
   assign w_pendVNext   = i_wrEn | r_pendV;
   assign w_pendClamped = CNT_W'(clamp_div(32'(w_pendNext)));
   assign w_wrap        = (r_cnt == r_div - CNT_W'(1));
   assign w_half        = CNT_W'(half_up(32'(r_div)));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_div    <= DIV_RESET;
         r_pend   <= '0;
         r_pendV  <= 1'b0;
         o_clkOut <= 1'b0;
         o_tick   <= 1'b0;
      end else if (!i_en) begin
         r_cnt    <= '0;
         r_pend   <= w_pendNext;
         r_pendV  <= 1'b0;
         o_clkOut <= 1'b0;
         o_tick   <= 1'b0;
         if (w_pendVNext) begin
            r_div <= w_pendClamped;
         end
      end else begin
         r_cnt    <= w_wrap ? '0 : r_cnt + CNT_W'(1);
         r_pend   <= w_pendNext;
         o_clkOut <= (r_cnt >= w_half);
         o_tick   <= w_wrap;
         if (w_wrap && w_pendVNext) begin
            r_div   <= w_pendClamped;
            r_pendV <= 1'b0;
         end else begin
            r_pendV <= w_pendVNext;
         end
      end
   end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: CH independent channels behind one write bus.
// This level only decodes the write address; all timing lives in clkdiv_chan.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int CH          = 2,
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 10
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [CH-1:0] en,
   clkdiv_multi_if.slave wr,
   output logic [CH-1:0] clk_out,
   output logic [CH-1:0] tick
);

   logic w_inRange;

   // Indices at or beyond CH address no channel and the write is dropped.
   assign w_inRange = (int'(wr.div_wr_ch) < CH);

   for (genvar i = 0; i < CH; i++) begin : g_chan
      logic w_sel;

      assign w_sel = wr.div_wr_en && w_inRange && (int'(wr.div_wr_ch) == i);

      clkdiv_chan #(
         .CNT_W       (CNT_W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_chan (
         .i_clk    (sys_clk),
         .i_rst    (sys_rst),
         .i_en     (en[i]),
         .i_wrEn   (w_sel),
         .i_wrData (wr.div_wr_data),
         .o_clkOut (clk_out[i]),
         .o_tick   (tick[i])
      );
   end

endmodule
